reg_value_uart_tx: RTL and testbench
====================================

// Module: reg_value_uart_tx
// PURPOSE
// - On-FPGA replacement for the simulation register monitor: watches the processor's
//   register_2_values bus and reports it as ASCII text over a UART line.
// - Frame format: "R2=" + 4 uppercase hex digits + CR + LF (9 bytes), 8N1, LSB first.
// - Sits beside pipe_MIPS32 in the FPGA top level; the tx pin drives the board USB-UART bridge.
// PARAMETERS
// - CLKS_PER_BIT  868  clocks per UART bit (100 MHz / 115200); legal range 2..65535
// - DATA_W        13   width of the monitored value; legal range 1..16, zero-extended to 16 bits
// PORTS
// - clk          in   1       system clock, all logic on rising edge
// - rst          in   1       synchronous, active-low reset
// - value        in   DATA_W  monitored register value (register_2_values)
// - tx           out  1       UART serial output, idle high
// - busy         out  1       1 while a frame is being sent
// - frame_done   out  1       1-cycle pulse when the last stop bit of a frame completes
// - dropped_cnt  out  8       saturating count of values overwritten before being sent
// BEHAVIOUR
// - Reset (rst=0 at an edge) forces: tx=1, busy=0, frame_done=0, dropped_cnt=0, FSM=IDLE,
//   pending=1, prev=value. Applies mid-frame too; the partial byte is abandoned and tx goes
//   high at that edge.
// - Change detect, every edge: if value != prev then prev<=value and latest<=value.
//   If this happens while pending=1 and busy=1, set pending and increment dropped_cnt
//   (saturate at 255). Otherwise set pending.
// - After reset, one frame is sent with the current value, as the monitor prints the
//   initial value.
// - FSM states: IDLE, START, DATA, STOP.
//   - IDLE: tx=1. If pending: snap<=latest (or value if changed this edge), pending<=0,
//     char_idx<=0, enter START at that edge. busy=1 from that edge on.
//   - START: tx=0 for CLKS_PER_BIT clocks, then DATA.
//   - DATA: 8 bits, LSB first, each held CLKS_PER_BIT clocks, then STOP.
//   - STOP: tx=1 for CLKS_PER_BIT clocks. At the end:
//     - if char_idx<8: char_idx++ and go to START (no gap between bytes).
//     - else: pulse frame_done. If pending, start the next frame on the same edge
//       (as in IDLE). Otherwise go to IDLE with busy=0.
// - Latency: tx falls on the first edge at which the change is sampled (1 clock).
// - Frame length: 9 x 10 x CLKS_PER_BIT clocks.
// - Snapshot rule: snap is frozen for the whole frame. Changes during a frame go to latest.
//   Only the newest value is sent afterwards; intermediate values count as dropped.
// - Character map, char_idx 0..8:
//   - 'R'(0x52), '2'(0x32), '='(0x3D)
//   - hex of snap[15:12], [11:8], [7:4], [3:0]
//   - CR(0x0D), LF(0x0A)
// - Hex encoding: 0-9 -> 0x30+n; A-F -> 0x41+(n-10).
// - Baud counter: width clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and then wraps.
//   No cumulative drift.
// - A value that changes and reverts between two edges is not detected (sampled design).
// TESTING (CLKS_PER_BIT=4, DATA_W=13, decode tx with a bench UART model)
// - Release reset with value=13'h0037, hold it stable -> one frame "R2=0037\r\n".
//   tx falls 1 clk after release; frame_done after 360 clks; then idle, busy=0.
// - Idle, then value 0x0037->0x1FFF -> "R2=1FFF\r\n", tx low 1 clk after change,
//   dropped_cnt=0.
// - During a frame, change value 0x0001->0x0002->0x0003 -> current frame unchanged;
//   next frame "R2=0003" starts on the frame_done edge; dropped_cnt=2.
// - 300 consecutive overwrites during one frame -> dropped_cnt saturates at 255.
// - Assert rst=0 mid-byte of char 4 -> tx=1 and busy=0 at that edge.
//   After release, a fresh full frame with the current value; no partial bytes decoded.
// - value constant for 2000 clks after the initial frame -> tx stays 1, no frame_done pulse.

Source files
------------

// File: rtl/reg_value_uart_tx.sv
// Register monitor: sends "R2=" + 4 hex digits + CR LF over an 8N1 UART whenever the
// watched value changes (and once after reset). Only the newest value is reported.
module reg_value_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_W       = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        dropped_cnt
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [3:0]        char_q, char_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [15:0]       snap_q, snap_d;
    logic [15:0]       latest_q, latest_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              pending_q, pending_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic [7:0]        drop_q, drop_d;
    logic              changed, baud_last, start_frame;
    logic [15:0]       value16;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] char_of(input logic [3:0] idx, input logic [15:0] s);
        case (idx)
            4'd0:    return 8'h52;
            4'd1:    return 8'h32;
            4'd2:    return 8'h3D;
            4'd3:    return hex_char(s[15:12]);
            4'd4:    return hex_char(s[11:8]);
            4'd5:    return hex_char(s[7:4]);
            4'd6:    return hex_char(s[3:0]);
            4'd7:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    assign value16 = 16'(value);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            char_q    <= '0;
            shreg_q   <= '0;
            snap_q    <= '0;
            latest_q  <= value16;
            prev_q    <= value;
            pending_q <= 1'b1;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            char_q    <= char_d;
            shreg_q   <= shreg_d;
            snap_q    <= snap_d;
            latest_q  <= latest_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        char_d      = char_q;
        shreg_d     = shreg_q;
        snap_d      = snap_q;
        tx_d        = tx_q;
        done_d      = 1'b0;
        start_frame = 1'b0;
        changed     = (value != prev_q);
        baud_last   = (baud_q == BAUD_LAST);
        latest_d    = changed ? value16 : latest_q;
        prev_d      = changed ? value : prev_q;
        pending_d   = pending_q | changed;
        drop_d      = drop_q;
        if (changed && pending_q && (state_q != IDLE) && (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;

        // tx is registered: each branch loads the level the line must carry after this edge
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (pending_q || changed)
                    start_frame = 1'b1;
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (char_q != 4'd8) begin
                        char_d  = char_q + 4'd1;
                        shreg_d = char_of(char_q + 4'd1, snap_q);
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        done_d = 1'b1;
                        tx_d   = 1'b1;
                        if (pending_q || changed)
                            start_frame = 1'b1;
                        else
                            state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase

        if (start_frame) begin
            snap_d    = latest_d;
            pending_d = 1'b0;
            char_d    = '0;
            shreg_d   = 8'h52;
            state_d   = START;
            baud_d    = '0;
            tx_d      = 1'b0;
        end
    end

    assign tx          = tx_q;
    assign busy        = (state_q != IDLE);
    assign frame_done  = done_q;
    assign dropped_cnt = drop_q;

endmodule

// File: tb/tb_reg_value_uart_tx.sv
// Randomized bench for reg_value_uart_tx: a timestamp-level reference model predicts
// tx/busy/frame_done/dropped_cnt per cycle, and a UART receiver checks decoded bytes.
module tb_reg_value_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 9 * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] value;
    logic        tx, busy, frame_done;
    logic [7:0]  dropped_cnt;

    int n_checks = 0;
    int n_errors = 0;

    reg_value_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(13)) dut (
        .clk(clk), .rst(rst), .value(value), .tx(tx), .busy(busy),
        .frame_done(frame_done), .dropped_cnt(dropped_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model (evaluated at each rising edge) ----------------
    string       hexd = "0123456789ABCDEF";
    int          cyc = 0;
    bit          m_valid = 0;
    bit          m_rst_seen;
    bit          m_busy, m_pending;
    logic [12:0] m_prev;
    logic [15:0] m_latest;
    int          m_start;
    int          m_drop;
    logic [7:0]  m_bytes [9];
    logic [7:0]  exp_q [$];
    logic        exp_tx, exp_busy, exp_done;

    always @(posedge clk) begin
        cyc++;
        m_valid  = 1;
        exp_done = 0;
        if (!rst) begin
            m_rst_seen = 1;
            m_busy     = 0;
            m_pending  = 1;
            m_prev     = value;
            m_latest   = {3'b000, value};
            m_drop     = 0;
            exp_q.delete();
            exp_tx     = 1;
        end else begin
            m_rst_seen = 0;
            if (value != m_prev) begin
                if (m_pending && m_busy && m_drop < 255) m_drop++;
                m_pending = 1;
                m_latest  = {3'b000, value};
                m_prev    = value;
            end
            if (m_busy && (cyc - m_start) == FRAME) begin
                exp_done = 1;
                m_busy   = 0;
            end
            if (!m_busy && m_pending) begin
                m_busy     = 1;
                m_pending  = 0;
                m_start    = cyc;
                m_bytes[0] = "R";
                m_bytes[1] = "2";
                m_bytes[2] = "=";
                for (int d = 0; d < 4; d++)
                    m_bytes[3+d] = hexd[(m_latest >> (12 - 4*d)) & 16'hF];
                m_bytes[7] = 8'h0D;
                m_bytes[8] = 8'h0A;
                for (int b = 0; b < 9; b++) exp_q.push_back(m_bytes[b]);
            end
            if (m_busy) begin
                int off, ch, bp;
                off = cyc - m_start;
                ch  = off / (10 * CPB);
                bp  = (off % (10 * CPB)) / CPB;
                if (bp == 0)      exp_tx = 0;
                else if (bp == 9) exp_tx = 1;
                else              exp_tx = m_bytes[ch][bp-1];
            end else begin
                exp_tx = 1;
            end
        end
        exp_busy = m_busy;
    end

    // ---------------- per-cycle output checks ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("tx", {31'd0, tx}, {31'd0, exp_tx});
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
            check("dropped_cnt", {24'd0, dropped_cnt}, m_drop);
        end
    end

    // ---------------- UART receiver ----------------
    int         rx_t = -1;
    logic [7:0] rx_byte;

    always @(negedge clk) begin
        if (!m_valid || m_rst_seen) begin
            rx_t = -1;
        end else if (rx_t < 0) begin
            if (tx == 1'b0) begin
                rx_t    = 0;
                rx_byte = '0;
            end
        end else begin
            rx_t++;
            if (rx_t >= CPB + CPB/2 && rx_t <= 8*CPB + CPB/2 && (rx_t % CPB) == CPB/2)
                rx_byte[(rx_t - CPB - CPB/2) / CPB] = tx;
            if (rx_t == 9*CPB + CPB/2) begin
                check("rx_stop", {31'd0, tx}, 32'd1);
                if (exp_q.size() == 0)
                    check("rx_unexpected", {24'd0, rx_byte}, 32'hFFFF_FFFF);
                else
                    check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
                rx_t = -1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b0;
        value = 13'h0037;
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(FRAME + 40);

        value = 13'h1FFF;
        wait_cycles(FRAME + 20);

        // overwrites during a frame: only the newest value follows
        value = 13'h0010;
        wait_cycles(30);
        value = 13'h0001;
        wait_cycles(40);
        value = 13'h0002;
        wait_cycles(40);
        value = 13'h0003;
        wait_cycles(2 * FRAME + 40);

        // saturation of the drop counter
        value = 13'h0100;
        wait_cycles(2);
        for (int i = 0; i < 300; i++) begin
            value = 13'h0200 + 13'(i);
            wait_cycles(1);
        end
        wait_cycles(2 * FRAME + 40);

        // reset in the middle of char 4
        value = 13'h0ABC;
        wait_cycles(4 * 10 * CPB + 17);
        rst = 1'b0;
        wait_cycles(1);
        rst = 1'b1;
        wait_cycles(FRAME + 40);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) begin
                value = 13'($urandom);
                wait_cycles($urandom_range(1, 450));
            end else if (r < 9) begin
                int n;
                n = $urandom_range(1, 20);
                for (int k = 0; k < n; k++) begin
                    value = 13'($urandom);
                    wait_cycles($urandom_range(1, 5));
                end
            end else begin
                rst = 1'b0;
                wait_cycles($urandom_range(1, 3));
                rst = 1'b1;
                wait_cycles($urandom_range(1, 100));
            end
        end
        wait_cycles(2 * FRAME + 40);

        // steady value: line must stay idle
        wait_cycles(2000);
        check("rx_leftover", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
